// File: rtl/ai_paddle_ctrl.sv
// AI paddle controller: reaction-delayed ball tracking with return-to-centre.
// Optional macro AI_SPEED_LIMIT_EN throttles the AI to 3 moves per 4 ticks.
module ai_paddle_ctrl #(
    parameter int unsigned PADDLE_H    = 200,
    parameter int unsigned Y_MAX       = 280,
    parameter int unsigned CENTER_Y    = 140,
    parameter int unsigned DEAD_ZONE   = 8,
    parameter int unsigned REACT_DELAY = 4
) (
    input  logic       game_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] ball_y,
    input  logic       ball_approach,
    input  logic [9:0] paddle_y,
    output logic       up,
    output logic       down
);

    typedef enum logic [1:0] {IDLE, WAIT, TRACK, CENTER} state_t;

    localparam logic [3:0]         DELAY_LAST = 4'(REACT_DELAY);
    localparam logic [10:0]        HALF_H     = 11'(PADDLE_H / 2);
    localparam logic [9:0]         Y_MAX_V    = 10'(Y_MAX);
    localparam logic signed [11:0] CENTER_REF = 12'(CENTER_Y);
    localparam logic signed [11:0] DZ_POS     = 12'(DEAD_ZONE);
    localparam logic signed [11:0] DZ_NEG     = -DZ_POS;

    state_t             state_q, state_d;
    logic [3:0]         dly_q, dly_d;
    logic               approach_q;
    logic               up_q, up_d;
    logic               down_q, down_d;
    logic               rise, fall;
    logic               move_ok;
    logic [10:0]        centre;
    logic signed [11:0] err;

    assign rise = ball_approach & ~approach_q;
    assign fall = ~ball_approach & approach_q;

    always_ff @(posedge game_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            approach_q <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            approach_q <= ball_approach;
            up_q       <= up_d;
            down_q     <= down_d;
        end
    end

`ifdef AI_SPEED_LIMIT_EN
    logic [1:0] thr_q;

    always_ff @(posedge game_clk) begin
        if (rst) thr_q <= '0;
        else     thr_q <= thr_q + 2'd1;
    end
`endif

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            dly_d   = '0;
            state_d = ball_approach ? WAIT : CENTER;
        end else if (rise) begin
            state_d = WAIT;
            dly_d   = '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (fall)                     state_d = CENTER;
                    else if (dly_q == DELAY_LAST) state_d = TRACK;
                    else                          dly_d   = dly_q + 4'd1;
                end
                TRACK: begin
                    if (fall) state_d = CENTER;
                end
                default: ;
            endcase
        end
    end

    // Moves are only issued while both the current and the next state steer the paddle,
    // so entering WAIT or IDLE silences the outputs on that very edge.
    always_comb begin
        centre  = {1'b0, paddle_y} + HALF_H;
        move_ok = (state_q == TRACK || state_q == CENTER) &&
                  (state_d == TRACK || state_d == CENTER);
        if (state_d == TRACK)
            err = $signed({2'b00, ball_y}) - $signed({1'b0, centre});
        else
            err = CENTER_REF - $signed({2'b00, paddle_y});

        up_d   = 1'b0;
        down_d = 1'b0;
        if (move_ok) begin
            up_d   = (err < DZ_NEG) && (paddle_y != '0);
            down_d = (err > DZ_POS) && (paddle_y < Y_MAX_V);
        end
`ifdef AI_SPEED_LIMIT_EN
        if (thr_q == 2'd3) begin
            up_d   = 1'b0;
            down_d = 1'b0;
        end
`endif
    end

    assign up   = up_q;
    assign down = down_q;

endmodule

// File: doc/ai_paddle_ctrl.md
AI_PADDLE_CTRL -- requirements
Module: ai_paddle_ctrl

Interface
REQ-001 Parameter PADDLE_H, default 200: paddle height in pixels.
REQ-002 Parameter Y_MAX, default 280: maximum paddle top-edge y.
REQ-003 Parameter CENTER_Y, default 140: paddle top-edge y used as the rest position.
REQ-004 Parameter DEAD_ZONE, default 8: tolerance in pixels within which no move is commanded.
REQ-005 Parameter REACT_DELAY, default 4, range 0..15: game_clk cycles of reaction delay.
REQ-006 game_clk  input  1  game tick clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 enable  input  1  1 = AI drives the paddle; 0 = AI idle.
REQ-009 ball_y  input  10  ball top-edge y, unsigned.
REQ-010 ball_approach  input  1  1 while ball velocity points toward this paddle.
REQ-011 paddle_y  input  10  current paddle top-edge y, fed back from the paddle module.
REQ-012 up  output  1  registered move-up command, one pixel per asserted tick.
REQ-013 down  output  1  registered move-down command, one pixel per asserted tick.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT, TRACK, CENTER.
REQ-015 The block SHALL register ball_approach each cycle (approach_q) and detect its rising edge (ball_approach=1, approach_q=0) and falling edge.
REQ-016 Any state with enable=0 SHALL go to IDLE on the next edge; this overrides all other transitions.
REQ-017 IDLE with enable=1 SHALL go to WAIT if ball_approach=1, else to CENTER.
REQ-018 Any non-IDLE state on a rising edge of ball_approach SHALL go to WAIT and load the delay counter with 0.
REQ-019 WAIT SHALL increment the delay counter every cycle and go to TRACK on the cycle the counter equals REACT_DELAY; with REACT_DELAY=0, WAIT lasts exactly one cycle.
REQ-020 WAIT or TRACK on a falling edge of ball_approach SHALL go to CENTER.
REQ-021 CENTER SHALL remain in CENTER until a rising edge or enable=0.
REQ-022 The target in TRACK SHALL be the paddle centre, computed as paddle_y + PADDLE_H/2 in 11 bits, compared against ball_y.
REQ-023 The target in CENTER SHALL be paddle_y compared against CENTER_Y.
REQ-024 The error SHALL be computed as a 12-bit signed value (target_ref minus current); no truncation or wrap is permitted.
REQ-025 If error < -DEAD_ZONE, the next up SHALL be 1; if error > DEAD_ZONE, the next down SHALL be 1; otherwise both SHALL be 0. Both ends are inclusive dead zone.
REQ-026 up SHALL be forced to 0 when paddle_y == 0, and down SHALL be forced to 0 when paddle_y >= Y_MAX.
REQ-027 In IDLE and WAIT, up and down SHALL both be 0.
REQ-028 up and down SHALL never be 1 in the same cycle.
REQ-029 Outputs SHALL be registered: a decision made from inputs sampled at edge N appears on up/down after edge N+1 (one-cycle latency).

Reset
REQ-030 When rst=1 at a game_clk edge, the block SHALL set: state=IDLE, up=0, down=0, delay counter=0, approach_q=0, throttle counter=0.
REQ-031 rst SHALL override enable and all transitions, including mid-WAIT and mid-TRACK.
REQ-032 The first rising edge of ball_approach after reset SHALL be detected normally.

Configuration
REQ-033 With macro AI_SPEED_LIMIT_EN defined, the block SHALL use a free-running 2-bit throttle counter and force up=down=0 on ticks where the counter equals 3, limiting the AI to 3 moves per 4 ticks.
REQ-034 Without AI_SPEED_LIMIT_EN, no throttle counter SHALL exist, and commands SHALL be issued every tick per REQ-025.

Verification
REQ-035 Reset: assert rst for 2 cycles with enable=1 and ball_approach=1 -> up=0, down=0, state IDLE.
REQ-036 Reaction delay: enable=1, state CENTER, paddle_y=100, ball_y=400; raise ball_approach at edge N -> down=0 through edge N+5, down=1 after edge N+6 (REACT_DELAY=4).
REQ-037 Dead zone: TRACK, paddle_y=100, ball_y=205 (error +5) -> up=0, down=0; ball_y=209 -> down=1 one cycle later.
REQ-038 Boundaries: TRACK with paddle_y=0 and ball_y=10 -> up=0. TRACK with paddle_y=280 and ball_y=470 -> down=0.
REQ-039 Return to centre: ball_approach falls with paddle_y=40 -> CENTER; down=1 while paddle_y<132, then 0; with paddle_y held at 150, up=1.
REQ-040 Macro: AI_SPEED_LIMIT_EN defined, continuous TRACK with ball_y=470 and paddle_y=0 -> down repeats the pattern 1,1,1,0; undefined -> down held at 1.
